// File: rtl/rot_scheduler.sv
// rot_scheduler: sequencing controller for the four-digit rotating HEX display.
// Owns the step prescaler and the 2-bit rotation index s. Modes: IDLE (single
// steps on demand), RUN (continuous rotation) and ONCE (one full revolution).
//
// Optional feature macro: ROT_SCHED_SPEED_EN
//   defined   : speed selects the step divisor D = TICK_DIV >> speed
//   undefined : speed is ignored and D = TICK_DIV
//
// Output pulses: tick is high for exactly one cycle, in the first cycle a new
// s is visible; done is high for one cycle together with the fourth tick of a
// ONCE revolution. There is no back-pressure: the downstream muxes simply
// follow s.
module rot_scheduler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       run,
  input  logic       once,
  input  logic       step,
  input  logic       dir,
  input  logic [1:0] speed,
  output logic [1:0] s,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Width needed to hold TICK_DIV-1.
  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ONCE = 2'd2;

  // Terminal prescaler values (D-1) for each speed setting.
  localparam logic [PRE_W-1:0] TERM0 = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] TERM1 = PRE_W'((TICK_DIV >> 1) - 1);
  localparam logic [PRE_W-1:0] TERM2 = PRE_W'((TICK_DIV >> 2) - 1);
  localparam logic [PRE_W-1:0] TERM3 = PRE_W'((TICK_DIV >> 3) - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [PRE_W-1:0] term_val;
  logic             term;
  logic             adv;
  logic [1:0]       s_next;

`ifdef ROT_SCHED_SPEED_EN
  // Select the terminal count from the speed switches.
  always_comb begin
    term_val = TERM0;
    case (speed)
      2'd1:    term_val = TERM1;
      2'd2:    term_val = TERM2;
      2'd3:    term_val = TERM3;
      default: term_val = TERM0;
    endcase
  end
`else
  // Fixed divisor: speed is kept on the port but has no effect.
  logic [1:0] unused_speed;
  logic [PRE_W-1:0] unused_terms;
  assign unused_speed = speed;
  assign unused_terms = TERM1 ^ TERM2 ^ TERM3;
  assign term_val     = TERM0;
`endif

  // '>=' lets a mid-count speed increase terminate on the very next cycle.
  assign term   = (pre_q >= term_val);
  assign s_next = dir ? (s_q - 2'd1) : (s_q + 2'd1);

  // Next-state logic: mode transitions, prescaler, revolution counter, advance.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (run) begin
          state_d = ST_RUN;
        end else if (once) begin
          state_d = ST_ONCE;
          cnt_d   = 2'd0;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          // Leaving RUN wins over a coincident terminal count: no advance.
          state_d = ST_IDLE;
          pre_d   = '0;
        end else if (term) begin
          adv   = 1'b1;
          pre_d = '0;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_ONCE: begin
        if (run) begin
          // Promote to continuous rotation without restarting the count.
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else if (term) begin
          adv   = 1'b1;
          pre_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
        cnt_d   = 2'd0;
      end
    endcase
    if (adv) begin
      s_d    = s_next;
      tick_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= ST_IDLE;
      s_q     <= 2'd0;
      pre_q   <= '0;
      cnt_q   <= 2'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign s         = s_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/rot_scheduler.md
# rot_scheduler

Sequencing controller for the four-digit rotating HEX display. It owns the seconds prescaler and the 2-bit rotation index `s` that drives the digit-select multiplexers. It runs continuously, steps once on demand, or performs exactly one full revolution, at a speed selectable from switches. It sits between the board switches/keys and the mux/decoder datapath, and replaces the free-running prescaler-plus-counter pair in the display top.

## Interface
- `TICK_DIV`, default 50000000: base prescaler divisor in `clk` cycles per step; must be ≥ 16.
- `clk` input 1: system clock (CLOCK_50 at top).
- `aclr` input 1: asynchronous active-low reset.
- `run` input 1: level; high = continuous rotation.
- `once` input 1: single-cycle pulse; start one full revolution (4 steps).
- `step` input 1: single-cycle pulse; advance one position immediately.
- `dir` input 1: 0 = s increments, 1 = s decrements; sampled at every advance.
- `speed` input 2: divisor select, D = TICK_DIV >> speed.
- `s` output 2: rotation index to the digit muxes.
- `tick` output 1: one-cycle pulse, high in the first cycle a new `s` is visible.
- `busy` output 1: high in RUN or ONCE.
- `done` output 1: one-cycle pulse at completion of a ONCE revolution.

## Operation
- Prescaler `pre` width is clogb2(TICK_DIV-1). Terminal condition: `pre >= D-1`. Using `>=` means a speed increase mid-count terminates on the next cycle.
- Advance: s <= s+1 (dir=0) or s-1 (dir=1), mod 4 wrap (3→0, 0→3); tick <= 1. Otherwise tick <= 0.
- States: IDLE, RUN, ONCE; 2-bit revolution counter `cnt` is used in ONCE only.
- IDLE, checked in priority order:
  - run=1 → RUN, pre <= 0.
  - else once=1 → ONCE, pre <= 0, cnt <= 0.
  - else step=1 → advance, stay in IDLE.
  - pre is held at 0.
- RUN:
  - run=0 → IDLE, pre <= 0, s held, no advance even if terminal in the same cycle.
  - else terminal → advance, pre <= 0; else pre++.
- ONCE:
  - run=1 → RUN immediately, cnt discarded, pre kept.
  - else terminal → advance, pre <= 0, cnt++. On the 4th advance (cnt==3) → IDLE, done <= 1 with that tick; s is back at its start value.
- `once` and `step` are ignored outside IDLE. `dir` may change at any time and affects only the next advance.
- Reset (async, any state, mid-count included): state IDLE, s=0, pre=0, cnt=0, tick=0, done=0, busy=0. Outputs stay at these values until the first post-reset edge.

## Timing
- All outputs are registered. busy goes high the cycle after the edge that samples run/once.
- First advance occurs D edges after the RUN/ONCE entry edge; subsequent advances every D cycles while speed is constant.
- step in IDLE: s and tick update on the sampling edge (1-cycle latency).
- ONCE total: 4·D cycles from entry to the done pulse; busy falls in the same cycle done rises.
- Inputs are synchronous to clk; debouncing and pulse shaping happen upstream.

## Configuration
- `ROT_SCHED_SPEED_EN` defined: speed selects D = TICK_DIV >> speed as above.
- Not defined: the speed port is kept but ignored, D = TICK_DIV fixed, and prescaler compare logic is constant.

## Test plan
- TICK_DIV=16, speed=0, dir=0, run held high from reset release → tick every 16 cycles, s = 1,2,3,0,1; busy=1 throughout.
- dir=1 in RUN from s=0 → next advance gives s=3, then 2; tick spacing unchanged.
- IDLE, s=2, once pulse, speed=2 (D=4) → 4 ticks 4 cycles apart, s=3,0,1,2, done with the 4th tick, busy low after.
- IDLE step pulse ×3, dir=0 → s=1,2,3, each with a tick the following cycle; step pulse during RUN → no effect.
- RUN with pre=10 (D=16), speed switched to 2 → advance on the next cycle, then every 4 cycles; run dropped on a terminal cycle → no advance, busy=0, s held.
- aclr asserted mid-ONCE with s=3 → s=0, busy=0, done=0 asynchronously; after release, stays IDLE with no tick.
